hazard_control_unit: RTL and testbench
======================================

// Module: hazard_control_unit
// PURPOSE
//  Parametrised pipeline hazard controller for the 5-stage core, sitting beside the FD/DX/XM pipeline registers.
//  Detects RAW data hazards against the DX and XM stages and stalls FD for a configurable load latency.
//  Detects control hazards (jump, taken branch) and flushes FD for a configurable number of slots.
//  Optionally produces forwarding selects, so only load-use hazards stall.
// PARAMETERS
//  REG_W        5  register-address width; register 0 is never a hazard source
//  LOAD_LATENCY 1  stall cycles per load-use hazard (1..15)
//  FLUSH_SLOTS  1  cycles flush stays high per jump/taken branch (1..15)
//  CNT_W        4  width of the shared stall/flush down-counter
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      reset, asynchronous, active-low
//  fd_rs         in   REG_W  rs field of instruction in FD
//  fd_rt         in   REG_W  rt field of instruction in FD
//  fd_uses_rt    in   1      FD instruction reads rt (R-type, store, branch)
//  dx_rd         in   REG_W  destination register of DX instruction
//  dx_reg_write  in   1      DX instruction writes the register file
//  dx_mem_read   in   1      DX instruction is a load
//  xm_rd         in   REG_W  destination register of XM instruction
//  xm_reg_write  in   1      XM instruction writes the register file
//  jump          in   1      FD instruction is a jump
//  branch_taken  in   1      FD branch resolved taken (branch & equal)
//  load_enable   out  1      PC and FD register write enable; 0 = hold
//  dx_bubble     out  1      force NOP into DX on next edge
//  flush         out  1      squash FD contents on next edge
//  fwd_a_sel     out  2      rs forward select: 00 regfile, 01 XM, 10 DX (HDU_FORWARD_EN only)
//  fwd_b_sel     out  2      rt forward select, same encoding (HDU_FORWARD_EN only)
// BEHAVIOUR
//  Match rules: match_dx(r) = dx_reg_write & (dx_rd==r) & (r!=0); match_xm(r) likewise on XM.
//   rt is checked only when fd_uses_rt=1.
//  Hazard: load_hz = dx_mem_read & (match_dx(rs) | match_dx(rt)).
//   Without forwarding, data_hz = any match_dx or match_xm on rs/rt; with forwarding, data_hz = load_hz.
//  FSM states: RUN, STALL, FLUSH. Counter cnt is CNT_W bits. Both reset to RUN, cnt=0, asynchronously on rst=0.
//  Outputs are combinational from state and inputs. While rst=0: load_enable=1, dx_bubble=0, flush=0, fwd=00.
//  RUN, data_hz=1:
//   - load_enable=0, dx_bubble=1, flush=0.
//   - If load_hz and LOAD_LATENCY>1: go to STALL, cnt=LOAD_LATENCY-2.
//   - Otherwise stay in RUN and re-evaluate next cycle; the bubble propagates, clearing the hazard naturally.
//  RUN, data_hz=0, (jump|branch_taken)=1:
//   - flush=1, load_enable=1, dx_bubble=0.
//   - If FLUSH_SLOTS>1: go to FLUSH, cnt=FLUSH_SLOTS-2.
//  RUN, no event: load_enable=1, dx_bubble=0, flush=0.
//  STALL: load_enable=0, dx_bubble=1, flush=0.
//   - jump/branch_taken ignored; the branch re-resolves after the stall.
//   - cnt==0 -> RUN, else cnt-1.
//  FLUSH: flush=1, load_enable=1, dx_bubble=0.
//   - Hazard and control inputs ignored (wrong-path instructions).
//   - cnt==0 -> RUN, else cnt-1.
//  Priority in RUN: data hazard beats control hazard, because branch operands may be stale.
//  Reset asserted mid-STALL/FLUSH aborts immediately to RUN with reset outputs; no residual stall after release.
//  Total stall for one load-use = LOAD_LATENCY cycles; total flush per event = FLUSH_SLOTS cycles.
// CONFIGURATION
//  HDU_FORWARD_EN defined:
//   - fwd_a_sel/fwd_b_sel exist: 10 on match_dx (non-load), else 01 on match_xm, else 00. DX has priority over XM.
//   - Only load_hz stalls.
//  HDU_FORWARD_EN undefined:
//   - fwd ports are absent.
//   - Every DX/XM RAW match stalls (regfile writes first half, reads second half).
// TESTING
//  1 rst=0 mid-STALL (LOAD_LATENCY=3) -> outputs 1/0/0 immediately, state RUN. After release, no stall without a new hazard.
//  2 dx lw $t0; fd add uses $t0; LOAD_LATENCY=2 -> load_enable=0, dx_bubble=1 for exactly 2 cycles, then 1/0.
//  3 dx writes $0, fd reads $0 (rt and rs) -> no stall, no forward, load_enable=1.
//  4 jump=1, FLUSH_SLOTS=2 -> flush=1 for 2 cycles, load_enable=1 throughout; jump in 2nd cycle ignored.
//  5 load_hz and branch_taken same cycle -> stall only, flush=0. Branch_taken after stall -> flush=1.
//  6 FORWARD_EN: dx add $t1, xm add $t1, fd reads $t1 as rs -> fwd_a_sel=10, no stall. Without macro: stall 1 cycle.

Source files
------------

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline hazard controller: RAW stall, control flush, optional forwarding
//
// Purpose: sits beside the FD/DX/XM pipeline registers of the 5-stage core.
//   Stalls FD on RAW hazards against DX/XM (LOAD_LATENCY cycles per load-use),
//   flushes FD for FLUSH_SLOTS cycles on a jump or taken branch.
//   Optional feature macro: HDU_FORWARD_EN (adds forwarding selects; only load-use stalls).
//
// Ports:
//   i_clk            clock, rising edge
//   i_rst            reset, asynchronous, active-low
//   i_fd_rs/i_fd_rt  source register fields of the FD instruction
//   i_fd_uses_rt     FD instruction reads rt
//   i_dx_rd          DX destination register; i_dx_reg_write, i_dx_mem_read qualify it
//   i_xm_rd          XM destination register; i_xm_reg_write qualifies it
//   i_jump           FD instruction is a jump
//   i_branch_taken   FD branch resolved taken
//   o_load_enable    PC/FD write enable (0 = hold)
//   o_dx_bubble      force NOP into DX on next edge
//   o_flush          squash FD contents on next edge
//   o_fwd_a_sel      rs forward select 00 regfile, 01 XM, 10 DX (HDU_FORWARD_EN only)
//   o_fwd_b_sel      rt forward select, same encoding (HDU_FORWARD_EN only)

module hazard_control_unit #(
    parameter int REG_W        = 5,
    parameter int LOAD_LATENCY = 1,
    parameter int FLUSH_SLOTS  = 1,
    parameter int CNT_W        = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [REG_W-1:0] i_fd_rs,
    input  logic [REG_W-1:0] i_fd_rt,
    input  logic             i_fd_uses_rt,
    input  logic [REG_W-1:0] i_dx_rd,
    input  logic             i_dx_reg_write,
    input  logic             i_dx_mem_read,
    input  logic [REG_W-1:0] i_xm_rd,
    input  logic             i_xm_reg_write,
    input  logic             i_jump,
    input  logic             i_branch_taken,
    output logic             o_load_enable,
    output logic             o_dx_bubble,
    output logic             o_flush
`ifdef HDU_FORWARD_EN
    ,
    output logic [1:0]       o_fwd_a_sel,
    output logic [1:0]       o_fwd_b_sel
`endif
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // The cycle that enters STALL/FLUSH is already the first slot, so the
    // counter is loaded with (total - 2) and the state exits when it hits 0.
    localparam logic [CNT_W-1:0] LP_STALL_INIT = CNT_W'((LOAD_LATENCY > 1) ? LOAD_LATENCY - 2 : 0);
    localparam logic [CNT_W-1:0] LP_FLUSH_INIT = CNT_W'((FLUSH_SLOTS > 1) ? FLUSH_SLOTS - 2 : 0);
    localparam logic [CNT_W-1:0] LP_ONE        = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic w_dx_rs, w_dx_rt, w_xm_rs, w_xm_rt;
    logic w_load_hz, w_data_hz, w_ctrl_hz;

    // Register 0 is hard-wired, so it never creates a dependency.
    assign w_dx_rs = i_dx_reg_write && (i_dx_rd == i_fd_rs) && (i_fd_rs != '0);
    assign w_dx_rt = i_dx_reg_write && (i_dx_rd == i_fd_rt) && (i_fd_rt != '0) && i_fd_uses_rt;
    assign w_xm_rs = i_xm_reg_write && (i_xm_rd == i_fd_rs) && (i_fd_rs != '0);
    assign w_xm_rt = i_xm_reg_write && (i_xm_rd == i_fd_rt) && (i_fd_rt != '0) && i_fd_uses_rt;

    assign w_load_hz = i_dx_mem_read && (w_dx_rs || w_dx_rt);
    assign w_ctrl_hz = i_jump || i_branch_taken;

`ifdef HDU_FORWARD_EN
    assign w_data_hz = w_load_hz;

    // A load result is not ready in DX, so DX only forwards non-load results.
    always_comb begin
        o_fwd_a_sel = 2'b00;
        o_fwd_b_sel = 2'b00;
        if (w_dx_rs && !i_dx_mem_read) o_fwd_a_sel = 2'b10;
        else if (w_xm_rs)              o_fwd_a_sel = 2'b01;
        if (w_dx_rt && !i_dx_mem_read) o_fwd_b_sel = 2'b10;
        else if (w_xm_rt)              o_fwd_b_sel = 2'b01;
        if (!i_rst) begin
            o_fwd_a_sel = 2'b00;
            o_fwd_b_sel = 2'b00;
        end
    end
`else
    assign w_data_hz = w_dx_rs || w_dx_rt || w_xm_rs || w_xm_rt;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        o_load_enable = 1'b1;
        o_dx_bubble   = 1'b0;
        o_flush       = 1'b0;
        case (r_state)
            ST_RUN: begin
                // Data hazard wins: branch operands may still be stale.
                if (w_data_hz) begin
                    o_load_enable = 1'b0;
                    o_dx_bubble   = 1'b1;
                    if (w_load_hz && (LOAD_LATENCY > 1)) begin
                        w_state_nxt = ST_STALL;
                        w_cnt_nxt   = LP_STALL_INIT;
                    end
                end else if (w_ctrl_hz) begin
                    o_flush = 1'b1;
                    if (FLUSH_SLOTS > 1) begin
                        w_state_nxt = ST_FLUSH;
                        w_cnt_nxt   = LP_FLUSH_INIT;
                    end
                end
            end
            ST_STALL: begin
                o_load_enable = 1'b0;
                o_dx_bubble   = 1'b1;
                if (r_cnt == '0) w_state_nxt = ST_RUN;
                else             w_cnt_nxt   = r_cnt - LP_ONE;
            end
            ST_FLUSH: begin
                o_flush = 1'b1;
                if (r_cnt == '0) w_state_nxt = ST_RUN;
                else             w_cnt_nxt   = r_cnt - LP_ONE;
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
        if (!i_rst) begin
            o_load_enable = 1'b1;
            o_dx_bubble   = 1'b0;
            o_flush       = 1'b0;
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - randomized scoreboard bench for hazard_control_unit

module tb_hazard_control_unit;

    localparam int N = 2;
    localparam int LL [N] = '{2, 3};
    localparam int FS [N] = '{2, 1};

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] fd_rs = '0, fd_rt = '0, dx_rd = '0, xm_rd = '0;
    logic       fd_uses_rt = 1'b0, dx_reg_write = 1'b0, dx_mem_read = 1'b0;
    logic       xm_reg_write = 1'b0, jump = 1'b0, branch_taken = 1'b0;

    logic [N-1:0] le, bub, fl;
    logic [1:0]   fa [N];
    logic [1:0]   fb [N];

    always #5 clk = ~clk;

    hazard_control_unit #(.REG_W(5), .LOAD_LATENCY(2), .FLUSH_SLOTS(2), .CNT_W(4)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_fd_rs(fd_rs), .i_fd_rt(fd_rt), .i_fd_uses_rt(fd_uses_rt),
        .i_dx_rd(dx_rd), .i_dx_reg_write(dx_reg_write), .i_dx_mem_read(dx_mem_read),
        .i_xm_rd(xm_rd), .i_xm_reg_write(xm_reg_write), .i_jump(jump), .i_branch_taken(branch_taken),
        .o_load_enable(le[0]), .o_dx_bubble(bub[0]), .o_flush(fl[0])
`ifdef HDU_FORWARD_EN
        , .o_fwd_a_sel(fa[0]), .o_fwd_b_sel(fb[0])
`endif
    );

    hazard_control_unit #(.REG_W(5), .LOAD_LATENCY(3), .FLUSH_SLOTS(1), .CNT_W(4)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_fd_rs(fd_rs), .i_fd_rt(fd_rt), .i_fd_uses_rt(fd_uses_rt),
        .i_dx_rd(dx_rd), .i_dx_reg_write(dx_reg_write), .i_dx_mem_read(dx_mem_read),
        .i_xm_rd(xm_rd), .i_xm_reg_write(xm_reg_write), .i_jump(jump), .i_branch_taken(branch_taken),
        .o_load_enable(le[1]), .o_dx_bubble(bub[1]), .o_flush(fl[1])
`ifdef HDU_FORWARD_EN
        , .o_fwd_a_sel(fa[1]), .o_fwd_b_sel(fb[1])
`endif
    );

`ifndef HDU_FORWARD_EN
    assign fa[0] = 2'b00;
    assign fa[1] = 2'b00;
    assign fb[0] = 2'b00;
    assign fb[1] = 2'b00;
`endif

    typedef struct {
        logic [N-1:0] le;
        logic [N-1:0] bub;
        logic [N-1:0] fl;
        logic [1:0]   fa;
        logic [1:0]   fb;
        int           cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   done  = 1'b0;

    // Reference model: remaining stall / flush slots per instance.
    int stall_left [N] = '{0, 0};
    int flush_left [N] = '{0, 0};

    function automatic bit dep(input logic w, input logic [4:0] rd, input logic [4:0] r);
        return w && (rd == r) && (r != 0);
    endfunction

    task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt, input logic ut,
                         input logic [4:0] drd, input logic dw, input logic dm,
                         input logic [4:0] xrd, input logic xw, input logic j, input logic b);
        exp_t e;
        bit   a_dx, b_dx, a_xm, b_xm, load_hz, data_hz;
        @(posedge clk);
        #1;
        rst = r; fd_rs = rs; fd_rt = rt; fd_uses_rt = ut; dx_rd = drd; dx_reg_write = dw;
        dx_mem_read = dm; xm_rd = xrd; xm_reg_write = xw; jump = j; branch_taken = b;
        cyc++;
        a_dx = dep(dw, drd, rs);
        b_dx = ut && dep(dw, drd, rt);
        a_xm = dep(xw, xrd, rs);
        b_xm = ut && dep(xw, xrd, rt);
        load_hz = dm && (a_dx || b_dx);
`ifdef HDU_FORWARD_EN
        data_hz = load_hz;
        e.fa = (!r) ? 2'b00 : (a_dx && !dm) ? 2'b10 : a_xm ? 2'b01 : 2'b00;
        e.fb = (!r) ? 2'b00 : (b_dx && !dm) ? 2'b10 : b_xm ? 2'b01 : 2'b00;
`else
        data_hz = a_dx || b_dx || a_xm || b_xm;
        e.fa = 2'b00;
        e.fb = 2'b00;
`endif
        e.cyc = cyc;
        for (int k = 0; k < N; k++) begin
            e.le[k] = 1'b1; e.bub[k] = 1'b0; e.fl[k] = 1'b0;
            if (!r) begin
                stall_left[k] = 0;
                flush_left[k] = 0;
            end else if (stall_left[k] > 0) begin
                e.le[k] = 1'b0; e.bub[k] = 1'b1;
                stall_left[k]--;
            end else if (flush_left[k] > 0) begin
                e.fl[k] = 1'b1;
                flush_left[k]--;
            end else if (data_hz) begin
                e.le[k] = 1'b0; e.bub[k] = 1'b1;
                if (load_hz) stall_left[k] = LL[k] - 1;
            end else if (j || b) begin
                e.fl[k] = 1'b1;
                flush_left[k] = FS[k] - 1;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 5'd0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    endtask

    // Monitor: outputs settle after the driver's update; sample on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            for (int k = 0; k < N; k++) begin
                tests += 4;
                if (le[k] !== e.le[k]) begin
                    fails++; $display("FAIL load_enable inst%0d cyc%0d got %b want %b", k, e.cyc, le[k], e.le[k]);
                end
                if (bub[k] !== e.bub[k]) begin
                    fails++; $display("FAIL dx_bubble inst%0d cyc%0d got %b want %b", k, e.cyc, bub[k], e.bub[k]);
                end
                if (fl[k] !== e.fl[k]) begin
                    fails++; $display("FAIL flush inst%0d cyc%0d got %b want %b", k, e.cyc, fl[k], e.fl[k]);
                end
                if ({fa[k], fb[k]} !== {e.fa, e.fb}) begin
                    fails++; $display("FAIL fwd_sel inst%0d cyc%0d got %b/%b want %b/%b", k, e.cyc, fa[k], fb[k], e.fa, e.fb);
                end
            end
        end
    end

    initial begin
        int guard;
        // Reset state
        drive(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
        drive(0, 5'd8, 5'd8, 1, 5'd8, 1, 1, 5'd8, 1, 1, 1);
        idle(2);
        // Load-use on $t0, then reset asserted mid-stall and released
        drive(1, 5'd8, 5'd9, 1, 5'd8, 1, 1, 5'd0, 0, 0, 0);
        idle(1);
        drive(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
        idle(4);
        // Clean load-use on $t0 for the full latency
        drive(1, 5'd8, 5'd9, 1, 5'd8, 1, 1, 5'd0, 0, 0, 0);
        idle(4);
        // $0 is never a hazard
        drive(1, 5'd0, 5'd0, 1, 5'd0, 1, 1, 5'd0, 1, 0, 0);
        drive(1, 5'd0, 5'd0, 1, 5'd0, 1, 0, 5'd0, 1, 0, 0);
        // Jump, with a second jump in the slot that follows
        drive(1, 5'd1, 5'd2, 0, 5'd3, 0, 0, 5'd4, 0, 1, 0);
        drive(1, 5'd1, 5'd2, 0, 5'd3, 0, 0, 5'd4, 0, 1, 0);
        idle(3);
        // Load-use and taken branch together, branch re-resolves after the stall
        drive(1, 5'd9, 5'd10, 1, 5'd10, 1, 1, 5'd0, 0, 0, 1);
        drive(1, 5'd9, 5'd10, 1, 5'd0, 0, 0, 5'd10, 1, 0, 1);
        drive(1, 5'd9, 5'd10, 1, 5'd0, 0, 0, 5'd0, 0, 0, 1);
        drive(1, 5'd9, 5'd10, 1, 5'd0, 0, 0, 5'd0, 0, 0, 1);
        idle(3);
        // DX and XM both write $t1, FD reads $t1 as rs
        drive(1, 5'd9, 5'd0, 0, 5'd9, 1, 0, 5'd9, 1, 0, 0);
        idle(3);
        // Randomized traffic over a small register window to provoke matches
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 39) != 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                  5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                  5'($urandom_range(0, 3)), 1'($urandom),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0));
        end
        idle(2);
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
